memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
// DLX MEM stage. Producer of the data_from_memory / data_from_alu operands consumed by write_back_stage.
// Runs loads and stores against the data RAM over a req/ready handshake.
// Formats byte/half/word data in big-endian order and sign- or zero-extends loads.
// Stalls the pipeline until the RAM access completes.
// PARAMETERS
// N            32  datapath width; only 32 is legal (elaboration assertion)
// ADDR_W       32  RAM address width
// TIMEOUT_CYC  16  max cycles in ACCESS waiting for ram_ready before abort (>=2)
// PORTS
// clk               in   1       system clock, rising edge
// rst               in   1       asynchronous reset, active-low
// mem_op_valid      in   1       instruction in MEM stage is a load/store
// mem_we            in   1       1=store, 0=load
// mem_size          in   2       00=byte, 01=half, 10=word, 11=word (reserved)
// mem_unsigned      in   1       1=zero-extend load, 0=sign-extend
// addr_in           in   ADDR_W  effective address from ALU
// store_data        in   N       store operand (rs2)
// alu_result_in     in   N       ALU result forwarded to WB
// data_from_memory  out  N       formatted load result (registered)
// data_from_alu     out  N       registered alu_result_in
// stall             out  1       hold upstream pipeline registers
// misaligned_exc    out  1       1-cycle pulse, misaligned access rejected
// bus_err           out  1       1-cycle pulse, RAM timeout
// ram_req           out  1       RAM request, held until ready
// ram_we            out  1       RAM write enable
// ram_addr          out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
// ram_be            out  4       byte enables; bit3 = bits[31:24] = byte offset 0
// ram_wdata         out  N       store data replicated across lanes
// ram_rdata         in   N       RAM read data, valid when ram_ready=1
// ram_ready         in   1       RAM completes access this cycle
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, timeout counter=0. Asserting rst mid-access drops ram_req immediately.
// - FSM states: IDLE, ACCESS, DONE.
// - IDLE, mem_op_valid=1, aligned: capture addr, size, unsigned flag, we and formatted wdata/be. Next state ACCESS.
// - Alignment: a half needs addr[0]=0; a word needs addr[1:0]=0.
// - IDLE, mem_op_valid=1, misaligned: no RAM access, misaligned_exc=1 for 1 cycle, stall=0, stay IDLE.
// - ACCESS: ram_req=1 with stable we/addr/be/wdata.
// - ACCESS, ram_ready=1: a load registers extracted+extended ram_rdata into data_from_memory. Next state DONE.
// - ACCESS, ram_ready=0: counter++. At counter==TIMEOUT_CYC-1, bus_err pulses 1 cycle, data_from_memory is unchanged, next state DONE.
// - DONE: stall=0 and the result is valid for WB. Next state is IDLE unconditionally; an op seen in DONE is not re-accepted.
// - stall = (IDLE & mem_op_valid & aligned) | ACCESS. Minimum 2 stall cycles per access.
// - data_from_alu <= alu_result_in on every edge where stall=0. It holds while stalled.
// - Byte lanes (big-endian), off=addr[1:0]:
//     byte: be = 4'b1000>>off, wdata = {4{store_data[7:0]}}
//     half: be = off[1] ? 0011 : 1100, wdata = {2{store_data[15:0]}}
//     word: be = 1111
// - Load extract: byte lane = rdata[31-8*off -: 8]; half lane = off[1] ? rdata[15:0] : rdata[31:16]. Extend per mem_unsigned.
// - Stores never modify data_from_memory.
// TESTING
// - LW addr 0x100, rdata 0xDEADBEEF, ready 1 cycle after req -> ram_be=1111; stall high 2 cycles; data_from_memory=0xDEADBEEF in DONE.
// - LB addr 0x103 signed, rdata 0x000000F0 -> 0xFFFFFFF0. Same access with LBU -> 0x000000F0.
// - SH addr 0x202, store_data 0x1234ABCD -> ram_we=1, ram_be=0011, ram_wdata=0xABCDABCD; data_from_memory unchanged.
// - LW addr 0x101 -> misaligned_exc 1-cycle pulse, ram_req never asserted, stall=0.
// - ram_ready held 0 -> after TIMEOUT_CYC cycles in ACCESS, bus_err pulses, FSM IDLE 2 cycles later, stall released.
// - rst low while ram_req=1 -> ram_req=0 and stall=0 asynchronously, before the next clk edge; a clean LW succeeds after release.

Source files
------------

// File: rtl/memory_access_stage.sv
// DLX MEM stage: runs loads/stores against the data RAM over a req/ready
// handshake, formatting big-endian byte/half/word lanes and stalling until done.
module memory_access_stage #(
  parameter int N           = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_op_valid,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [N-1:0]      store_data,
  input  logic [N-1:0]      alu_result_in,
  output logic [N-1:0]      data_from_memory,
  output logic [N-1:0]      data_from_alu,
  output logic              stall,
  output logic              misaligned_exc,
  output logic              bus_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [N-1:0]      ram_wdata,
  input  logic [N-1:0]      ram_rdata,
  input  logic              ram_ready,
  output logic [1:0]        dbg_state
);

  if (N != 32) begin : g_bad_width
    $error("memory_access_stage: N must be 32");
  end

  // RAM handshake: ram_req rises with a stable we/addr/be/wdata set and holds
  // until the cycle ram_ready=1 (transfer completes) or the timeout aborts it.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;

  logic [1:0]    off;
  logic          aligned;
  logic [3:0]    be_fmt;
  logic [N-1:0]  wdata_fmt;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [N-1:0]  load_fmt;

  assign off       = addr_in[1:0];
  assign dbg_state = state;

  always_comb begin
    aligned   = 1'b1;
    be_fmt    = 4'b1111;
    wdata_fmt = store_data;
    case (mem_size)
      2'b00: begin
        be_fmt    = 4'b1000 >> off;
        wdata_fmt = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~off[0];
        be_fmt    = off[1] ? 4'b0011 : 4'b1100;
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: aligned = (off == 2'b00);
    endcase
  end

  // Reset gates stall directly so the pipeline is released before the next edge.
  assign stall = rst & (((state == IDLE) & mem_op_valid & aligned) | (state == ACCESS));

  always_comb begin
    byte_lane = ram_rdata[8*(3-int'(off_q)) +: 8];
    half_lane = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    load_fmt  = ram_rdata;
    case (size_q)
      2'b00:   load_fmt = uns_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_fmt = uns_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_fmt = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      off_q            <= '0;
      size_q           <= '0;
      uns_q            <= 1'b0;
      data_from_memory <= '0;
      data_from_alu    <= '0;
      misaligned_exc   <= 1'b0;
      bus_err          <= 1'b0;
      ram_req          <= 1'b0;
      ram_we           <= 1'b0;
      ram_addr         <= '0;
      ram_be           <= '0;
      ram_wdata        <= '0;
    end else begin
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      if (!stall) data_from_alu <= alu_result_in;
      case (state)
        IDLE: begin
          if (mem_op_valid) begin
            if (aligned) begin
              off_q     <= off;
              size_q    <= mem_size;
              uns_q     <= mem_unsigned;
              ram_req   <= 1'b1;
              ram_we    <= mem_we;
              ram_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
              ram_be    <= be_fmt;
              ram_wdata <= wdata_fmt;
              cnt       <= '0;
              state     <= ACCESS;
            end else begin
              misaligned_exc <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            ram_req <= 1'b0;
            if (!ram_we) data_from_memory <= load_fmt;
            state   <= DONE;
          end else if (cnt == CNT_MAX) begin
            ram_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: a vector table of single accesses
// plus hand-written timeout and mid-access reset sequences.
module tb_memory_access_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_op_valid, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr_in, store_data, alu_result_in;
  logic [31:0] data_from_memory, data_from_alu;
  logic        stall, misaligned_exc, bus_err;
  logic        ram_req, ram_we, ram_ready;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic [1:0]  dbg_state;

  memory_access_stage #(.N(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mem_op_valid(mem_op_valid), .mem_we(mem_we),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr_in(addr_in),
    .store_data(store_data), .alu_result_in(alu_result_in),
    .data_from_memory(data_from_memory), .data_from_alu(data_from_alu),
    .stall(stall), .misaligned_exc(misaligned_exc), .bus_err(bus_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dfm;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_alu;
  logic [31:0] exp_dfm;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] new_alu;
    logic [31:0] waddr;
    new_alu = $urandom_range(32'h7fff_ffff, 1);
    waddr   = v.addr;
    waddr[1:0] = 2'b00;
    @(negedge clk);
    mem_op_valid  = 1'b1;
    mem_we        = v.we;
    mem_size      = v.size;
    mem_unsigned  = v.uns;
    addr_in       = v.addr;
    store_data    = v.sdata;
    alu_result_in = new_alu;
    ram_rdata     = 32'h5a5a_5a5a;
    #1 check($sformatf("v%0d stall_idle", idx), {31'd0, stall}, {31'd0, ~v.mis});
    @(posedge clk); #1;
    if (v.mis) begin
      check($sformatf("v%0d mis_exc", idx), {31'd0, misaligned_exc}, 32'd1);
      check($sformatf("v%0d mis_noreq", idx), {31'd0, ram_req}, 32'd0);
      check($sformatf("v%0d mis_state", idx), {30'd0, dbg_state}, 32'd0);
      check($sformatf("v%0d mis_alu", idx), data_from_alu, new_alu);
      mem_op_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d mis_pulse_end", idx), {31'd0, misaligned_exc}, 32'd0);
      check($sformatf("v%0d mis_stall", idx), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d mis_noreq2", idx), {31'd0, ram_req}, 32'd0);
    end else begin
      check($sformatf("v%0d acc_state", idx), {30'd0, dbg_state}, 32'd1);
      check($sformatf("v%0d req", idx), {31'd0, ram_req}, 32'd1);
      check($sformatf("v%0d we", idx), {31'd0, ram_we}, {31'd0, v.we});
      check($sformatf("v%0d addr", idx), ram_addr, waddr);
      check($sformatf("v%0d be", idx), {28'd0, ram_be}, {28'd0, v.be});
      if (v.we) check($sformatf("v%0d wdata", idx), ram_wdata, v.wdata);
      check($sformatf("v%0d stall_acc", idx), {31'd0, stall}, 32'd1);
      check($sformatf("v%0d alu_hold", idx), data_from_alu, exp_alu);
      mem_op_valid = 1'b0;
      ram_ready    = 1'b1;
      ram_rdata    = v.rdata;
      @(posedge clk); #1;
      ram_ready = 1'b0;
      check($sformatf("v%0d done_state", idx), {30'd0, dbg_state}, 32'd2);
      check($sformatf("v%0d done_req", idx), {31'd0, ram_req}, 32'd0);
      check($sformatf("v%0d done_stall", idx), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d dfm", idx), data_from_memory, v.dfm);
      @(posedge clk); #1;
      check($sformatf("v%0d idle_state", idx), {30'd0, dbg_state}, 32'd0);
      check($sformatf("v%0d alu_new", idx), data_from_alu, new_alu);
      exp_dfm = v.dfm;
    end
    exp_alu = new_alu;
  endtask

  initial begin
    //        we    size   uns   addr          sdata         rdata         mis   be       wdata         dfm
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hdead_beef, 1'b0, 4'b1111, 32'h0,        32'hdead_beef};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h0000_00f0, 1'b0, 4'b0001, 32'h0,        32'hffff_fff0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h0000_00f0, 1'b0, 4'b0001, 32'h0,        32'h0000_00f0};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_abcd, 32'h0,        1'b0, 4'b0011, 32'habcd_abcd, 32'h0000_00f0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'h8001_7fff, 1'b0, 4'b1100, 32'h0,        32'hffff_8001};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h1234_f00d, 1'b0, 4'b0011, 32'h0,        32'h0000_f00d};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00a5, 32'h0,        1'b0, 4'b0100, 32'ha5a5_a5a5, 32'h0000_f00d};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h1180_2233, 1'b0, 4'b0100, 32'h0,        32'hffff_ff80};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hcafe_f00d, 32'h0,        1'b0, 4'b1111, 32'hcafe_f00d, 32'hffff_ff80};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0204, 32'h0,        32'h0102_0304, 1'b0, 4'b1111, 32'h0,        32'h0102_0304};

    // clock/reset
    rst = 1'b0; mem_op_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    addr_in = '0; store_data = '0; alu_result_in = '0; ram_rdata = '0; ram_ready = 1'b0;
    exp_alu = '0; exp_dfm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dfm", data_from_memory, 32'd0);
    check("rst_alu", data_from_alu, 32'd0);
    check("rst_req", {31'd0, ram_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_be", {28'd0, ram_be}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // timeout: ram_ready never arrives
    @(negedge clk);
    mem_op_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; addr_in = 32'h0000_0400;
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    check("to_enter", {30'd0, dbg_state}, 32'd1);
    for (int i = 1; i < TO; i++) begin
      @(posedge clk); #1;
      check($sformatf("to_wait%0d", i), {29'd0, dbg_state, bus_err}, {29'd0, 2'd1, 1'b0});
      check($sformatf("to_stall%0d", i), {31'd0, stall}, 32'd1);
    end
    @(posedge clk); #1;
    check("to_buserr", {31'd0, bus_err}, 32'd1);
    check("to_done", {30'd0, dbg_state}, 32'd2);
    check("to_stall_rel", {31'd0, stall}, 32'd0);
    check("to_req_drop", {31'd0, ram_req}, 32'd0);
    check("to_dfm_keep", data_from_memory, exp_dfm);
    @(posedge clk); #1;
    check("to_idle", {30'd0, dbg_state}, 32'd0);
    check("to_buserr_end", {31'd0, bus_err}, 32'd0);

    // reset in the middle of an access, with the op still presented
    @(negedge clk);
    mem_op_valid = 1'b1; mem_size = 2'b10; addr_in = 32'h0000_0500;
    @(posedge clk); #1;
    check("ra_req_up", {31'd0, ram_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ra_req_async", {31'd0, ram_req}, 32'd0);
    check("ra_stall_async", {31'd0, stall}, 32'd0);
    check("ra_state", {30'd0, dbg_state}, 32'd0);
    mem_op_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_alu = alu_result_in;
    exp_dfm = '0;
    run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h7654_3210, 1'b0, 4'b1111, 32'h0, 32'h7654_3210}, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
